sbox_sub_pipe: RTL
==================

// Module: sbox_sub_pipe
// PURPOSE
//  Multi-lane, elastic-pipelined AES byte-substitution unit. Each lane selects forward
//  SubBytes or InvSubBytes per beat. Encrypt and decrypt datapaths share this unit in
//  place of separate per-byte combinational lookup blocks. The S-box value is computed
//  arithmetically (GF(2^8) inverse over x^8+x^4+x^3+x+1, plus the affine transform or
//  its inverse), with no 256-entry tables.
// PARAMETERS
//  LANES   16  bytes per beat; each lane is independent (1..16)
//  STAGES  2   register stages from input to output, i.e. latency in cycles (1..4)
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          synchronous reset, active-high
//  in_valid   in   1          input beat present
//  in_ready   out  1          unit accepts beat this cycle
//  in_mode    in   1          0 = forward S-box, 1 = inverse S-box
//  in_data    in   8*LANES    lane i = in_data[8i+7:8i]
//  out_valid  out  1          output beat present
//  out_ready  in   1          consumer accepts beat this cycle
//  out_mode   out  1          mode the output beat was processed with
//  out_data   out  8*LANES    substituted bytes, lane-aligned with in_data
//  busy       out  1          any pipeline stage holds a valid beat
// BEHAVIOUR
//  - Reset: all stage valid bits, stored data and stored modes clear to 0.
//    After reset: out_valid=0, out_data=0, out_mode=0, busy=0, in_ready=1.
//  - Reset mid-operation discards every in-flight beat. No output is produced for them.
//  - Transfer rule: a beat moves on a cycle where valid && ready.
//    Input side: in_valid && in_ready. Output side: out_valid && out_ready.
//  - Substitution is computed combinationally from in_data/in_mode and captured in
//    stage 1. Stages 2..STAGES are retiming registers that carry {valid, mode, data}.
//  - Per-stage advance: stage k loads when it is empty or its content leaves this cycle.
//    ready[k] = !valid[k] || ready[k+1]; ready[STAGES+1] = out_ready; in_ready = ready[1].
//  - Ready is a combinational chain. There is no bubble penalty: a full pipe with
//    out_ready=1 accepts a new beat every cycle.
//  - Latency: a beat accepted in cycle t appears at out_* in cycle t+STAGES when
//    there is no backpressure. Throughput is 1 beat/cycle.
//  - out_valid/out_data/out_mode are the last stage's registers.
//    They stay stable while out_valid && !out_ready.
//  - in_ready=0 only when every stage is valid and out_ready=0.
//    in_data is ignored when in_valid=0 or in_ready=0.
//  - Mode is latched per beat and travels with its data. Mixed-mode back-to-back beats
//    are legal, with no flush and no penalty cycle.
//  - Ordering: strict FIFO. No beat is dropped, duplicated or reordered under
//    any out_ready pattern.
//  - Arithmetic: GF inverse of 0x00 is defined as 0x00.
//    Forward: S(x) = affine(inv(x)) ^ 0x63. Inverse: inv(affine^-1(x ^ 0x63)).
//    Results match FIPS-197 for all 256 inputs in both modes.
//  - busy = OR of all stage valid bits, registered-consistent (no glitch on transfers).
// TESTING
//  1. Hold rst for 2 cycles -> out_valid=0, out_data=0, out_mode=0, busy=0, in_ready=1.
//  2. LANES=16, STAGES=2, one beat of all bytes 0x00:
//     mode 0 -> {16{8'h63}} after 2 cycles; mode 1 -> {16{8'h52}}.
//  3. Sweep 0x00..0xFF through lanes in forward mode, feed the outputs back in inverse
//     mode -> identity. Spot values: fwd 0x19->0xD4, 0x53->0xED; inv 0xED->0x53, 0x63->0x00.
//  4. Stream 10 beats with out_ready=0 in cycles 3-6:
//     - in_ready drops once all stages are full;
//     - out_data holds steady while stalled;
//     - all 10 results arrive in order, with no loss or duplicates.
//  5. Back-to-back beats with in_mode alternating 0,1,0,1 and each in_data = 0x52 per lane
//     -> outputs 0x00,0x48,0x00,0x48; out_mode follows 0,1,0,1.
//  6. Two beats in flight, assert rst for 1 cycle -> next cycle out_valid=0, busy=0.
//     A beat accepted after reset returns the correct result with latency STAGES.

Source files
------------

// File: rtl/sbox_sub_pipe.sv
// sbox_sub_pipe: elastic multi-lane AES SubBytes/InvSubBytes; in_* handshake with mode/data, out_* handshake with mode/data, busy when any stage holds a beat
module sbox_sub_pipe #(
  parameter int LANES  = 16,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [8*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_mode,
  output logic [8*LANES-1:0] out_data,
  output logic               busy
);
  localparam int W = 8*LANES;
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? t : 8'h00);
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), x);
    return gf_mul(r, r);
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] x, input logic inv);
    logic [7:0] a;
    logic [7:0] y;
    a = x ^ 8'h63;
    a = inv ? ({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]}) : x;
    y = gf_inv(a);
    return inv ? y : (y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63);
  endfunction
  logic [W-1:0]              sub_data;
  logic [STAGES-1:0]         rdy;
  logic [STAGES-1:0]         vld_q, vld_d, mode_q, mode_d;
  logic [STAGES-1:0][W-1:0]  data_q, data_d;
  always_comb begin
    sub_data = '0;
    for (int i = 0; i < LANES; i++) sub_data[8*i+:8] = sbox(in_data[8*i+:8], in_mode);
  end
  always_comb begin
    logic acc;
    acc = out_ready;
    for (int k = STAGES-1; k >= 0; k--) begin
      acc = !vld_q[k] || acc;
      rdy[k] = acc;
    end
  end
  always_comb begin
    vld_d  = vld_q;
    mode_d = mode_q;
    data_d = data_q;
    if (rdy[0]) begin
      vld_d[0] = in_valid;
      mode_d[0] = in_valid ? in_mode : mode_q[0];
      data_d[0] = in_valid ? sub_data : data_q[0];
    end
    for (int k = 1; k < STAGES; k++) begin
      if (rdy[k]) begin
        vld_d[k] = vld_q[k-1];
        mode_d[k] = vld_q[k-1] ? mode_q[k-1] : mode_q[k];
        data_d[k] = vld_q[k-1] ? data_q[k-1] : data_q[k];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      mode_q <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      mode_q <= mode_d;
      data_q <= data_d;
    end
  end
  assign in_ready  = rdy[0];
  assign out_valid = vld_q[STAGES-1];
  assign out_mode  = mode_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign busy      = |vld_q;
endmodule
